// File: rtl/jbi_snoop_resp_gen_pkg.sv
// Shared types for the JBus snoop-response generator: response codes, FSM states
// and the width of the internal countdown counters.
package jbi_snoop_resp_gen_pkg;

   localparam int SNP_CNT_W = 4;

   typedef enum logic [1:0] {
      SNP_NOP   = 2'b00,
      SNP_CLEAN = 2'b01,
      SNP_OWNED = 2'b10,
      SNP_HOLD  = 2'b11
   } snp_code_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLDING,
      ST_DRIVE,
      ST_GAP
   } snp_state_e;

   // The disable bit overrides ownership so the bus only ever sees CLEAN.
   function automatic snp_code_e final_code(input logic owned, input logic snp_disable);
      return (owned && !snp_disable) ? SNP_OWNED : SNP_CLEAN;
   endfunction

endpackage

// File: rtl/jbi_snoop_resp_timer.sv
// Loadable 4-bit down-counter with a count==1 flag; serves both the response
// latency wait and the post-response turnaround gap.
module jbi_snoop_resp_timer
   import jbi_snoop_resp_gen_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 load,
   input  logic [SNP_CNT_W-1:0] load_val,
   input  logic                 en,
   output logic                 is_one
);

   logic [SNP_CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign is_one = (count_reg == SNP_CNT_W'(1));

endmodule

// File: rtl/jbi_snoop_resp_gen.sv
// Pops one snoop request at a time, waits a fixed latency (plus optional HOLD
// cycles) and drives a single registered response code onto the JBus snoop pins.
module jbi_snoop_resp_gen
   import jbi_snoop_resp_gen_pkg::*;
#(
   parameter int SNP_RESP_LAT = 4,
   parameter int SNP_GAP      = 1,
   parameter int MAX_HOLD     = 15
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       sq_valid,
   output logic       sq_dequeue,
   input  logic       snp_owned,
   input  logic       snp_hold,
   input  logic       csr_snp_disable,
   output logic [1:0] j_snoop_out,
   output logic       j_snoop_oe,
   output logic       resp_done,
   output logic       hold_timeout
);

   localparam logic [SNP_CNT_W-1:0] LAT_LOAD = SNP_CNT_W'(SNP_RESP_LAT - 1);
   localparam logic [SNP_CNT_W-1:0] GAP_LOAD = SNP_CNT_W'(SNP_GAP);
   localparam logic [SNP_CNT_W-1:0] HOLD_MAX = SNP_CNT_W'(MAX_HOLD);

   if (SNP_RESP_LAT < 2 || SNP_RESP_LAT > 15 || SNP_GAP < 0 || SNP_GAP > 7 ||
       MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_param
      $error("jbi_snoop_resp_gen: parameter out of legal range");
   end

   snp_state_e           state_reg, state_next;
   snp_code_e            code_cap_reg, code_cap_next;
   logic [SNP_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic                 timer_load, timer_en, timer_is_one;
   logic [SNP_CNT_W-1:0] timer_val;
   logic                 forced;

   snp_code_e            j_snoop_out_reg, j_snoop_out_next;
   logic                 oe_reg, oe_next;
   logic                 resp_done_reg, resp_done_next;
   logic                 hold_timeout_reg, hold_timeout_next;

   jbi_snoop_resp_timer u_timer (
      .clk      (clk),
      .rst_l    (rst_l),
      .load     (timer_load),
      .load_val (timer_val),
      .en       (timer_en),
      .is_one   (timer_is_one)
   );

   always_comb begin
      state_next    = state_reg;
      code_cap_next = code_cap_reg;
      hold_cnt_next = hold_cnt_reg;
      timer_load    = 1'b0;
      timer_val     = '0;
      timer_en      = 1'b0;
      forced        = 1'b0;
      sq_dequeue    = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            sq_dequeue = sq_valid;
            if (sq_valid) begin
               code_cap_next = final_code(snp_owned, csr_snp_disable);
               timer_load    = 1'b1;
               timer_val     = LAT_LOAD;
               state_next    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            timer_en = 1'b1;
            if (timer_is_one) begin
               if (snp_hold) begin
                  hold_cnt_next = SNP_CNT_W'(1);
                  state_next    = ST_HOLDING;
               end else begin
                  state_next = ST_DRIVE;
               end
            end
         end
         ST_HOLDING: begin
            if (!snp_hold) begin
               state_next = ST_DRIVE;
            end else if (hold_cnt_reg < HOLD_MAX) begin
               hold_cnt_next = hold_cnt_reg + 1'b1;
            end else begin
               forced     = 1'b1;
               state_next = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            hold_cnt_next = '0;
            if (SNP_GAP == 0) begin
               state_next = ST_IDLE;
            end else begin
               timer_load = 1'b1;
               timer_val  = GAP_LOAD;
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            timer_en = 1'b1;
            if (timer_is_one) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so the registered outputs line
   // up with the cycle the FSM spends in HOLDING/DRIVE.
   always_comb begin
      j_snoop_out_next  = SNP_NOP;
      oe_next           = 1'b0;
      resp_done_next    = 1'b0;
      hold_timeout_next = forced;
      unique case (state_next)
         ST_HOLDING: begin
            j_snoop_out_next = SNP_HOLD;
            oe_next          = 1'b1;
         end
         ST_DRIVE: begin
            j_snoop_out_next = code_cap_next;
            oe_next          = 1'b1;
            resp_done_next   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_reg        <= ST_IDLE;
         code_cap_reg     <= SNP_CLEAN;
         hold_cnt_reg     <= '0;
         j_snoop_out_reg  <= SNP_NOP;
         oe_reg           <= 1'b0;
         resp_done_reg    <= 1'b0;
         hold_timeout_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         code_cap_reg     <= code_cap_next;
         hold_cnt_reg     <= hold_cnt_next;
         j_snoop_out_reg  <= j_snoop_out_next;
         oe_reg           <= oe_next;
         resp_done_reg    <= resp_done_next;
         hold_timeout_reg <= hold_timeout_next;
      end
   end

   assign j_snoop_out  = j_snoop_out_reg;
   assign j_snoop_oe   = oe_reg;
   assign resp_done    = resp_done_reg;
   assign hold_timeout = hold_timeout_reg;

endmodule

// File: tb/tb_jbi_snoop_resp_gen.sv
// Bench for jbi_snoop_resp_gen: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a cycle-offset reference model.
module tb_jbi_snoop_resp_gen;

   localparam int LAT  = 4;
   localparam int GAP  = 1;
   localparam int MAXH = 15;
   localparam int LOGN = 8192;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       sq_valid = 1'b0;
   logic       snp_owned = 1'b0;
   logic       snp_hold = 1'b0;
   logic       csr_snp_disable = 1'b0;
   logic       sq_dequeue;
   logic [1:0] j_snoop_out;
   logic       j_snoop_oe;
   logic       resp_done;
   logic       hold_timeout;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   logic       log_deq  [LOGN];
   logic [1:0] log_code [LOGN];
   logic       log_oe   [LOGN];
   logic       log_done [LOGN];
   logic       log_to   [LOGN];

   // Reference model: one request tracked by its dequeue cycle and the cycle
   // its final code is due (-1 while still unknown because of HOLD).
   bit m_busy = 0;
   int m_t = 0, m_code = 0, m_drive = -1, m_h = 0, m_free = 0;
   bit m_forced = 0;

   jbi_snoop_resp_gen #(.SNP_RESP_LAT(LAT), .SNP_GAP(GAP), .MAX_HOLD(MAXH)) dut (
      .clk             (clk),
      .rst_l           (rst_l),
      .sq_valid        (sq_valid),
      .sq_dequeue      (sq_dequeue),
      .snp_owned       (snp_owned),
      .snp_hold        (snp_hold),
      .csr_snp_disable (csr_snp_disable),
      .j_snoop_out     (j_snoop_out),
      .j_snoop_oe      (j_snoop_oe),
      .resp_done       (resp_done),
      .hold_timeout    (hold_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      int e_deq, e_code, e_oe, e_done, e_to;
      e_deq = 0; e_code = 0; e_oe = 0; e_done = 0; e_to = 0;
      if (!rst_l) begin
         m_busy = 0;
         m_free = 0;
         chk("rst_code", int'(j_snoop_out), 0);
         chk("rst_oe", int'(j_snoop_oe), 0);
         chk("rst_done", int'(resp_done), 0);
         chk("rst_timeout", int'(hold_timeout), 0);
      end else begin
         e_deq = (sq_valid && !m_busy && cyc >= m_free) ? 1 : 0;
         if (m_busy && m_drive == cyc) begin
            e_code = m_code; e_oe = 1; e_done = 1; e_to = m_forced ? 1 : 0;
         end else if (m_busy && cyc >= m_t + LAT) begin
            e_code = 3; e_oe = 1;
         end
         chk("dequeue", int'(sq_dequeue), e_deq);
         chk("code", int'(j_snoop_out), e_code);
         chk("oe", int'(j_snoop_oe), e_oe);
         chk("resp_done", int'(resp_done), e_done);
         chk("hold_timeout", int'(hold_timeout), e_to);
         if (e_done == 1)
            $display("resp cycle=%0d code=%0d hold_cycles=%0d timeout=%0d", cyc, e_code, m_h, e_to);
         if (e_deq == 1) begin
            m_busy = 1; m_t = cyc; m_drive = -1; m_h = 0; m_forced = 0;
            m_code = (snp_owned && !csr_snp_disable) ? 2 : 1;
         end else if (m_busy) begin
            if (m_drive == cyc) begin
               m_busy = 0;
               m_free = cyc + 1 + GAP;
            end else if (m_drive < 0 && cyc == m_t + LAT - 1) begin
               if (snp_hold) m_h = 1;
               else m_drive = cyc + 1;
            end else if (m_drive < 0 && cyc >= m_t + LAT) begin
               if (!snp_hold) m_drive = cyc + 1;
               else if (m_h == MAXH) begin m_drive = cyc + 1; m_forced = 1; end
               else m_h++;
            end
         end
      end
      if (cyc < LOGN) begin
         log_deq[cyc]  = sq_dequeue;
         log_code[cyc] = j_snoop_out;
         log_oe[cyc]   = j_snoop_oe;
         log_done[cyc] = resp_done;
         log_to[cyc]   = hold_timeout;
      end
   end

   task automatic step(input logic v, input logic o, input logic h, input logic c);
      @(posedge clk);
      #1;
      sq_valid = v; snp_owned = o; snp_hold = h; csr_snp_disable = c;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int t, t2, n;
      bit heavy;
      repeat (3) @(posedge clk);
      #1 rst_l = 1'b1;
      repeat (4) step(0, 0, 0, 0);

      // single owned request, no hold
      step(1, 1, 0, 0); t = cyc;
      repeat (9) step(0, 0, 0, 0);
      settle();
      chk("A_deq_T", int'(log_deq[t]), 1);
      chk("A_oe_T3", int'(log_oe[t+3]), 0);
      chk("A_code_T4", int'(log_code[t+4]), 2);
      chk("A_oe_T4", int'(log_oe[t+4]), 1);
      chk("A_done_T4", int'(log_done[t+4]), 1);
      chk("A_oe_T5", int'(log_oe[t+5]), 0);
      chk("A_done_T5", int'(log_done[t+5]), 0);

      // three queued requests, owned 0,1,0
      step(1, 0, 0, 0); t = cyc;
      for (int k = 1; k <= 12; k++) step(1, (k == 6), 0, 0);
      repeat (10) step(0, 0, 0, 0);
      settle();
      n = 0;
      for (int k = 0; k <= 20; k++) n += int'(log_deq[t+k]);
      chk("B_deq_count", n, 3);
      chk("B_deq_T6", int'(log_deq[t+6]), 1);
      chk("B_deq_T12", int'(log_deq[t+12]), 1);
      chk("B_code_T4", int'(log_code[t+4]), 1);
      chk("B_code_T10", int'(log_code[t+10]), 2);
      chk("B_code_T16", int'(log_code[t+16]), 1);

      // hold for three cycles starting at T+3
      step(1, 0, 0, 0); t = cyc;
      for (int k = 1; k <= 12; k++) step(0, 0, (k >= 3 && k <= 5), 0);
      settle();
      chk("C_code_T3", int'(log_code[t+3]), 0);
      chk("C_code_T4", int'(log_code[t+4]), 3);
      chk("C_code_T6", int'(log_code[t+6]), 3);
      chk("C_code_T7", int'(log_code[t+7]), 1);
      chk("C_done_T7", int'(log_done[t+7]), 1);
      chk("C_to_T7", int'(log_to[t+7]), 0);

      // stuck hold forces a response after MAX_HOLD cycles
      step(1, 1, 0, 0); t = cyc;
      for (int k = 1; k <= 25; k++) step(0, 0, (k >= 3), 0);
      repeat (4) step(0, 0, 0, 0);
      settle();
      chk("D_code_T4", int'(log_code[t+4]), 3);
      chk("D_code_T18", int'(log_code[t+18]), 3);
      chk("D_done_T18", int'(log_done[t+18]), 0);
      chk("D_code_T19", int'(log_code[t+19]), 2);
      chk("D_to_T19", int'(log_to[t+19]), 1);
      chk("D_to_T18", int'(log_to[t+18]), 0);

      // csr disable captured at dequeue, toggled during WAIT
      step(1, 1, 0, 1); t = cyc;
      for (int k = 1; k <= 8; k++) step(0, 1, 0, logic'(k % 2));
      settle();
      chk("E_code_T4", int'(log_code[t+4]), 1);

      // asynchronous reset while HOLDING
      step(1, 0, 0, 0); t = cyc;
      for (int k = 1; k <= 5; k++) step(0, 0, (k >= 3), 0);
      step(0, 0, 1, 0);
      #2 rst_l = 1'b0;
      #1;
      chk("F_code_async", int'(j_snoop_out), 0);
      chk("F_oe_async", int'(j_snoop_oe), 0);
      chk("F_done_async", int'(resp_done), 0);
      chk("F_code_T5", int'(log_code[t+5]), 3);
      @(posedge clk);
      #1;
      rst_l = 1'b1; snp_hold = 1'b0;
      step(1, 0, 0, 0); t2 = cyc;
      repeat (6) step(0, 0, 0, 0);
      settle();
      chk("F_deq_after_rst", int'(log_deq[t2]), 1);
      chk("F_code_after_rst", int'(log_code[t2+4]), 1);

      // randomized traffic, alternating light and heavy hold pressure
      heavy = 0;
      for (int i = 0; i < 2500; i++) begin
         if (i % 200 == 0) heavy = ~heavy;
         step(logic'($urandom_range(0, 99) < 50), logic'($urandom % 2),
              logic'($urandom_range(0, 99) < (heavy ? 95 : 30)), logic'($urandom % 2));
      end
      repeat (30) step(0, 0, 0, 0);
      settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
